// File: rtl/walu_seq_core.sv
// Multi-cycle word ALU with valid/ready request and response channels.
// Simple ops finish in one cycle; MUL/DIVU/REMU iterate bit-serially for DATA_WIDTH cycles.

package walu_pkg;
    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MUL  = 3'd5,
        OP_DIVU = 3'd6,
        OP_REMU = 3'd7
    } op_e;
endpackage

module walu_seq_core #(
    parameter int DATA_WIDTH = walu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic                  out_dbz
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_nextState;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_dbzPend;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_carry;
    logic                  r_zero;
    logic                  r_dbz;

    logic                  w_isIterative;
    logic [DATA_WIDTH-1:0] w_addend;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_simpleResult;
    logic                  w_simpleCarry;
    logic [DATA_WIDTH-1:0] w_mulAcc;
    logic [DATA_WIDTH:0]   w_remShift;
    logic [DATA_WIDTH:0]   w_remDiff;
    logic                  w_remFits;
    logic [DATA_WIDTH-1:0] w_remNext;
    logic [DATA_WIDTH-1:0] w_quoNext;
    logic [DATA_WIDTH-1:0] w_iterResult;
    logic                  w_lastIter;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_carry  = r_carry;
    assign out_zero   = r_zero;
    assign out_dbz    = r_dbz;

    assign w_isIterative = (in_op == walu_pkg::OP_MUL) || (in_op == walu_pkg::OP_DIVU) ||
                           (in_op == walu_pkg::OP_REMU);
    assign w_lastIter    = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_nextState = w_isIterative ? S_BUSY : S_DONE;
            S_BUSY:  if (w_lastIter) w_nextState = S_DONE;
            S_DONE:  if (out_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // SUB reuses the adder as a + ~b + 1 so its carry doubles as "no borrow".
    always_comb begin
        w_addend       = (in_op == walu_pkg::OP_SUB) ? ~in_b : in_b;
        w_sum          = {1'b0, in_a} + {1'b0, w_addend} +
                         {{DATA_WIDTH{1'b0}}, (in_op == walu_pkg::OP_SUB)};
        w_simpleResult = w_sum[DATA_WIDTH-1:0];
        w_simpleCarry  = w_sum[DATA_WIDTH];
        case (in_op)
            walu_pkg::OP_AND: begin
                w_simpleResult = in_a & in_b;
                w_simpleCarry  = 1'b0;
            end
            walu_pkg::OP_OR: begin
                w_simpleResult = in_a | in_b;
                w_simpleCarry  = 1'b0;
            end
            walu_pkg::OP_XOR: begin
                w_simpleResult = in_a ^ in_b;
                w_simpleCarry  = 1'b0;
            end
            default: ;
        endcase
    end

    // The remainder needs one extra bit after the shift; a zero divisor always fits,
    // which naturally yields an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        w_mulAcc   = r_y[0] ? (r_acc + r_x) : r_acc;
        w_remShift = {r_acc, r_x[DATA_WIDTH-1]};
        w_remDiff  = w_remShift - {1'b0, r_y};
        w_remFits  = (w_remShift >= {1'b0, r_y});
        w_remNext  = w_remFits ? w_remDiff[DATA_WIDTH-1:0] : w_remShift[DATA_WIDTH-1:0];
        w_quoNext  = {r_x[DATA_WIDTH-2:0], w_remFits};
        case (r_op)
            walu_pkg::OP_MUL:  w_iterResult = w_mulAcc;
            walu_pkg::OP_DIVU: w_iterResult = w_quoNext;
            default:           w_iterResult = w_remNext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dbzPend <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op  <= in_op;
                        r_x   <= in_a;
                        r_y   <= in_b;
                        r_acc <= '0;
                        if (w_isIterative) begin
                            r_cnt     <= CNT_W'(DATA_WIDTH);
                            r_dbzPend <= (in_op != walu_pkg::OP_MUL) && (in_b == '0);
                        end else begin
                            r_result <= w_simpleResult;
                            r_carry  <= w_simpleCarry;
                            r_zero   <= (w_simpleResult == '0);
                            r_dbz    <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_op == walu_pkg::OP_MUL) begin
                        r_acc <= w_mulAcc;
                        r_x   <= r_x << 1;
                        r_y   <= r_y >> 1;
                    end else begin
                        r_acc <= w_remNext;
                        r_x   <= w_quoNext;
                    end
                    if (w_lastIter) begin
                        r_result <= w_iterResult;
                        r_carry  <= 1'b0;
                        r_zero   <= (w_iterResult == '0);
                        r_dbz    <= r_dbzPend;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_walu_seq_core.sv
// Scoreboard bench for walu_seq_core: directed corner cases plus randomized traffic
// checked against an arithmetic reference model with decoupled monitor.

module tb_walu_seq_core;

    localparam int W = 32;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIVU = 3'd6;
    localparam logic [2:0] OP_REMU = 3'd7;

    typedef struct {
        logic [W-1:0] result;
        logic         carry;
        logic         zero;
        logic         dbz;
        int           latency;
        int           acceptCycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = 3'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_dbz;

    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   seenValid = 1'b0;
    bit   randomReady = 1'b0;
    bit   forcedReady = 1'b1;

    walu_seq_core #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_dbz    (out_dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #2;
        out_ready = randomReady ? ($urandom_range(0, 3) != 0) : forcedReady;
    end

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] wide;
        e.carry       = 1'b0;
        e.dbz         = 1'b0;
        e.latency     = 1;
        e.acceptCycle = 0;
        e.result      = '0;
        case (op)
            OP_ADD: begin
                wide     = 64'(a) + 64'(b);
                e.result = wide[W-1:0];
                e.carry  = wide[W];
            end
            OP_SUB: begin
                e.result = a - b;
                e.carry  = (a >= b);
            end
            OP_AND: e.result = a & b;
            OP_OR:  e.result = a | b;
            OP_XOR: e.result = a ^ b;
            OP_MUL: begin
                wide      = 64'(a) * 64'(b);
                e.result  = wide[W-1:0];
                e.latency = W + 1;
            end
            default: begin
                e.latency = W + 1;
                if (b == '0) begin
                    e.dbz    = 1'b1;
                    e.result = (op == OP_DIVU) ? '1 : a;
                end else begin
                    e.result = (op == OP_DIVU) ? (a / b) : (a % b);
                end
            end
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   waitCycles = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (in_ready !== 1'b1 && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(op, a, b);
        e.acceptCycle = cycle + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // Monitor: compares every presented response against the scoreboard head,
    // checks first-valid latency, and retires an entry on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (out_valid !== 1'b1) begin
                seenValid = 1'b0;
            end else if (q.size() == 0) begin
                checkOutput("unexpected_response", 64'(out_result), 64'hDEAD_0000_0000_0000);
            end else begin
                e = q[0];
                if (!seenValid) begin
                    seenValid = 1'b1;
                    checkOutput("latency", 64'(cycle), 64'(e.acceptCycle + e.latency - 1));
                end
                checkOutput("result", 64'(out_result), 64'(e.result));
                checkOutput("carry", 64'(out_carry), 64'(e.carry));
                checkOutput("zero", 64'(out_zero), 64'(e.zero));
                checkOutput("dbz", 64'(out_dbz), 64'(e.dbz));
                if (out_ready === 1'b1) begin
                    void'(q.pop_front());
                    seenValid = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", 64'(out_result), 64'd0);
        checkOutput("reset_flags", 64'({out_carry, out_zero, out_dbz}), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a multiply must discard it entirely.
        applyStimulus(OP_MUL, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        applyStimulus(OP_ADD, 32'd1, 32'd1);

        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(OP_SUB, 32'd5, 32'd7);
        applyStimulus(OP_SUB, 32'd7, 32'd5);
        applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        applyStimulus(OP_OR, 32'h0, 32'h0);

        applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0001);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checkOutput("mul_busy_in_ready", 64'(in_ready), 64'd0);
        end

        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        applyStimulus(OP_REMU, 32'd100, 32'd7);
        applyStimulus(OP_DIVU, 32'd9, 32'd0);
        applyStimulus(OP_REMU, 32'd9, 32'd0);
        applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        waitDrain(200);

        // Backpressure: result must hold and no request may be taken while DONE.
        forcedReady = 1'b0;
        applyStimulus(OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            in_valid = (i % 2 == 0);
            in_a     = $urandom;
            in_op    = 3'($urandom);
        end
        @(negedge clk);
        in_valid    = 1'b0;
        forcedReady = 1'b1;
        n = 0;
        while (!(out_valid === 1'b1 && out_ready === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_handshake_seen", 64'(out_valid & out_ready), 64'd1);
        checkOutput("bp_handshake_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("bp_after_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_after_in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with random backpressure.
        randomReady = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 :
                 ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            if (op == OP_SUB && $urandom_range(0, 5) == 0) b = a;
            applyStimulus(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitDrain(4000);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/walu_seq_core.md
Name: walu_seq_core

Overview:
- Multi-cycle word ALU. It is the responder side of the walu operand/result handshake that the bench driver initiates.
- Accepts one operation (two DATA_WIDTH operands plus an opcode) over a valid/ready request channel and returns the result over a valid/ready response channel.
- Simple ops complete in one cycle. MUL/DIVU/REMU iterate bit-serially for DATA_WIDTH cycles.
- Sits behind the walu bench driver/monitor. Operand and result type is the package data_t, DATA_WIDTH bits wide.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; must be >= 2; matches the walu package value.
- CNT_W, $clog2(DATA_WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  core can accept a request.
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL (low half), 6 DIVU, 7 REMU.
- in_a  in  DATA_WIDTH  operand A (dividend for DIVU/REMU).
- in_b  in  DATA_WIDTH  operand B (divisor for DIVU/REMU).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  DATA_WIDTH  result word.
- out_carry  out  1  ADD: carry out. SUB: 1 when a >= b unsigned (no borrow). All other ops: 0.
- out_zero  out  1  1 when out_result == 0.
- out_dbz  out  1  1 for DIVU/REMU with in_b == 0, else 0.

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled on the clock edge only.
- Reset: state=IDLE; in_ready=1 on the cycle after the reset edge; out_valid=0; out_result=0; out_carry=0; out_zero=0; out_dbz=0; counter=0.
- A reset asserted mid-BUSY or mid-DONE discards the operation. No response is ever produced for it.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). It is a registered-state decode only, with no combinational path from out_ready.
- Accept: in_valid && in_ready at an edge. The core latches in_op, in_a and in_b. Inputs are ignored at all other times.
- IDLE, accept of a simple op (ADD/SUB/AND/OR/XOR):
  - The result and flags are computed from the inputs and registered at the same edge.
  - Next state is DONE, so out_valid is high 1 cycle after the accept edge.
- IDLE, accept of MUL:
  - Multiplicand register = a; multiplier register = b; accumulator = 0; counter = DATA_WIDTH; next state BUSY.
  - Each BUSY edge: if multiplier[0], accumulator += multiplicand (mod 2^DATA_WIDTH); multiplicand <<= 1; multiplier >>= 1; counter -= 1.
- IDLE, accept of DIVU/REMU:
  - Restoring division. Remainder register = 0; quotient register = a; counter = DATA_WIDTH.
  - Each BUSY edge: shift {rem,quo} left by 1; if rem >= b, rem -= b and set quo[0]=1; counter -= 1.
- BUSY -> DONE on the edge where counter goes 1->0. That same edge loads out_result and the flags.
  - out_valid is therefore high DATA_WIDTH+1 cycles after the accept edge.
  - Iteration logic is unsigned only. Multiply wraps to the low DATA_WIDTH bits.
- Divide by zero:
  - The loop still runs the full DATA_WIDTH iterations, so latency is unchanged.
  - DIVU result = all ones. REMU result = a. out_dbz=1.
- DONE:
  - out_valid=1. out_result and all flags are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, next state is IDLE and out_valid drops. in_ready rises in the following cycle, so there is no back-to-back accept.
  - Minimum request-to-request spacing is 2 cycles for simple ops.
- ADD/SUB results wrap modulo 2^DATA_WIDTH.
  - SUB is computed as a + ~b + 1. out_carry is the carry out of that sum.
- out_zero is evaluated on the final registered result for every op, including MUL and DIVU/REMU.
- An illegal state encoding returns to IDLE on the next edge with out_valid=0.

Test Plan:
- Reset mid-BUSY: accept MUL a=3 b=5, assert rst_n=0 at cycle 10 after accept -> out_valid=0 and in_ready=1 after the reset edge. The following ADD 1+1 returns 2 with no stale result.
- ADD 32'hFFFF_FFFF + 32'h1, out_ready=1 -> out_valid at accept+1, result 0, out_carry=1, out_zero=1. SUB 5-7 -> result 32'hFFFF_FFFE, out_carry=0. SUB 7-5 -> result 2, out_carry=1.
- MUL 32'h0001_0000 * 32'h0001_0001 -> out_valid exactly at accept+33, result 32'h0001_0000 (wrapped). in_ready=0 throughout BUSY.
- DIVU 100/7 -> result 14. REMU 100/7 -> result 2. DIVU 9/0 -> result 32'hFFFF_FFFF, out_dbz=1. REMU 9/0 -> result 9, out_dbz=1. Latency 33 cycles in every case.
- Backpressure: XOR 32'hA5A5_A5A5 ^ 32'h5A5A_5A5A, hold out_ready=0 for 5 cycles while toggling in_valid/in_a -> result stays 32'hFFFF_FFFF, no new accept. Release out_ready -> one handshake, then in_ready=1 on the next cycle.
